// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if: command, ALU and response bundle between host, sequencer and ALU
interface alu_cmd_sequencer_if #(parameter int WIDTH = 8);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_sel;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_use_acc;
  logic             cmd_wr_acc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;
  logic [WIDTH-1:0] acc;
  logic [15:0]      op_count;
  modport master (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, cmd_wr_acc, alu_result, alu_carry, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, acc, op_count
  );
  modport slave (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_use_acc, cmd_wr_acc, alu_result, alu_carry, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_zero, rsp_err, acc, op_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: valid/ready command sequencer driving a combinational ALU with an accumulator
module alu_cmd_sequencer #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  alu_cmd_sequencer_if.master b
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t r_state, w_next;
  logic w_legal, w_accept, r_wr_acc, r_carry, r_zero, r_err;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_acc, r_data;
  logic [2:0] r_sel;
  logic [15:0] r_cnt;
  assign w_legal = !(b.cmd_sel[2] && b.cmd_sel[1]);
  always_comb begin
    w_accept = r_state == IDLE && b.cmd_valid;
    w_next = r_state;
    if (w_accept) w_next = w_legal ? EXEC : RESP;
    else if (r_state == EXEC) w_next = RESP;
    else if (r_state == RESP && b.rsp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_sel <= '0;
      r_acc <= '0;
      r_data <= '0;
      r_carry <= 1'b0;
      r_zero <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_wr_acc <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_legal) begin
        r_alu_a <= b.cmd_use_acc ? r_acc : b.cmd_a;
        r_alu_b <= b.cmd_b;
        r_sel <= b.cmd_sel;
        r_wr_acc <= b.cmd_wr_acc;
      end
      if (w_accept && !w_legal) begin
        r_data <= '0;
        r_carry <= 1'b0;
        r_zero <= 1'b0;
        r_err <= 1'b1;
      end
      if (r_state == EXEC) begin
        r_data <= b.alu_result;
        r_carry <= b.alu_carry;
        r_zero <= b.alu_result == '0;
        r_err <= 1'b0;
        r_cnt <= r_cnt + 16'd1;
        if (r_wr_acc) r_acc <= b.alu_result;
      end
    end
  end
  assign b.cmd_ready = r_state == IDLE;
  assign b.rsp_valid = r_state == RESP;
  assign b.alu_a = r_alu_a;
  assign b.alu_b = r_alu_b;
  assign b.alu_sel = r_sel;
  assign b.rsp_data = r_data;
  assign b.rsp_carry = r_carry;
  assign b.rsp_zero = r_zero;
  assign b.rsp_err = r_err;
  assign b.acc = r_acc;
  assign b.op_count = r_cnt;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed plus random commands checked against a behavioural sequencer model
module tb_alu_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [7:0] ref_acc, ref_a, ref_b, exp_data;
  logic [2:0] ref_sel;
  logic [15:0] ref_cnt;
  logic exp_carry, exp_err;
  alu_cmd_sequencer_if #(.WIDTH(8)) bus ();
  alu_cmd_sequencer #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .b(bus.master));
  always #5 clk = ~clk;
  always_comb begin
    bus.alu_result = 8'h00;
    bus.alu_carry = 1'b0;
    case (bus.alu_sel)
      3'd0: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1: {bus.alu_carry, bus.alu_result} = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_result = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'd5: bus.alu_result = ~bus.alu_a;
      default: bus.alu_result = 8'h00;
    endcase
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [8:0] model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    int sum;
    if (s == 3'd0) begin
      sum = int'(a) + int'(b);
      return {sum > 255, sum[7:0]};
    end
    if (s == 3'd1) begin
      sum = int'(a) - int'(b);
      return {a < b, sum[7:0]};
    end
    if (s == 3'd2) return {1'b0, a & b};
    if (s == 3'd3) return {1'b0, a | b};
    if (s == 3'd4) return {1'b0, a ^ b};
    return {1'b0, ~a};
  endfunction
  task automatic chk_rsp();
    chk("rsp_valid", bus.rsp_valid, 1);
    chk("cmd_ready_busy", bus.cmd_ready, 0);
    chk("rsp_data", bus.rsp_data, exp_data);
    chk("rsp_carry", bus.rsp_carry, exp_carry);
    chk("rsp_zero", bus.rsp_zero, !exp_err && exp_data == 0);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("acc", bus.acc, ref_acc);
    chk("op_count", bus.op_count, ref_cnt);
    chk("alu_sel", bus.alu_sel, ref_sel);
  endtask
  task automatic send(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b, input logic use_acc, input logic wr);
    logic [8:0] r;
    bus.cmd_sel = s;
    bus.cmd_a = a;
    bus.cmd_b = b;
    bus.cmd_use_acc = use_acc;
    bus.cmd_wr_acc = wr;
    bus.cmd_valid = 1'b1;
    chk("ready_before_accept", bus.cmd_ready, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    if (s >= 3'd6) begin
      exp_data = 8'h00;
      exp_carry = 1'b0;
      exp_err = 1'b1;
      chk_rsp();
      return;
    end
    ref_a = use_acc ? ref_acc : a;
    ref_b = b;
    ref_sel = s;
    chk("lat_legal_early", bus.rsp_valid, 0);
    chk("exec_ready", bus.cmd_ready, 0);
    chk("alu_a", bus.alu_a, ref_a);
    chk("alu_b", bus.alu_b, ref_b);
    r = model(s, ref_a, b);
    exp_data = r[7:0];
    exp_carry = r[8];
    exp_err = 1'b0;
    ref_cnt++;
    if (wr) ref_acc = r[7:0];
    @(negedge clk);
    chk_rsp();
  endtask
  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
    chk("idle_ready", bus.cmd_ready, 1);
  endtask
  initial begin
    logic [7:0] tab_a [6] = '{8'h0F, 8'h10, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
    logic [7:0] tab_b [6] = '{8'h01, 8'h02, 8'hCC, 8'hCC, 8'hCC, 8'hCC};
    logic [7:0] tab_r [6] = '{8'h10, 8'h0E, 8'h88, 8'hEE, 8'h66, 8'h55};
    bus.cmd_valid = 1'b0;
    bus.cmd_sel = 3'd0;
    bus.cmd_a = 8'h00;
    bus.cmd_b = 8'h00;
    bus.cmd_use_acc = 1'b0;
    bus.cmd_wr_acc = 1'b0;
    bus.rsp_ready = 1'b0;
    ref_acc = 0; ref_a = 0; ref_b = 0; ref_sel = 0; ref_cnt = 0;
    exp_data = 0; exp_carry = 0; exp_err = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_count", bus.op_count, 0);
    chk("rst_alu_sel", bus.alu_sel, 0);
    chk("rst_err", bus.rsp_err, 0);
    for (int i = 0; i < 6; i++) begin
      send(3'(i), tab_a[i], tab_b[i], 1'b0, 1'b0);
      chk("plan_result", bus.rsp_data, tab_r[i]);
      ack();
      repeat (2) @(negedge clk);
    end
    chk("plan_count6", bus.op_count, 6);
    send(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1);
    chk("wrap_carry", bus.rsp_carry, 1);
    chk("wrap_zero", bus.rsp_zero, 1);
    ack();
    send(3'd0, 8'h05, 8'h03, 1'b0, 1'b1);
    chk("chain_acc8", bus.acc, 8'h08);
    ack();
    send(3'd0, 8'hEE, 8'h02, 1'b1, 1'b1);
    chk("chain_0a", bus.rsp_data, 8'h0A);
    ack();
    send(3'd4, 8'h77, 8'hFF, 1'b1, 1'b0);
    chk("chain_f5", bus.rsp_data, 8'hF5);
    chk("chain_acc_keep", bus.acc, 8'h0A);
    ack();
    send(3'd6, 8'h12, 8'h34, 1'b0, 1'b1);
    chk("illegal_sel_kept", bus.alu_sel, 3'd4);
    ack();
    send(3'd0, 8'h21, 8'h11, 1'b0, 1'b0);
    bus.cmd_sel = 3'd4;
    bus.cmd_a = 8'h3C;
    bus.cmd_b = 8'h0F;
    bus.cmd_use_acc = 1'b0;
    bus.cmd_wr_acc = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.cmd_valid = i[0];
      @(negedge clk);
      chk_rsp();
    end
    bus.cmd_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_idle_ready", bus.cmd_ready, 1);
    chk("bp_drop", bus.rsp_valid, 0);
    send(3'd4, 8'h3C, 8'h0F, 1'b0, 1'b1);
    chk("bp_new_acc", bus.acc, 8'h33);
    ack();
    for (int i = 0; i < 40; i++) begin
      send(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        chk_rsp();
      end
      ack();
    end
    bus.cmd_sel = 3'd0;
    bus.cmd_a = 8'h05;
    bus.cmd_b = 8'h06;
    bus.cmd_use_acc = 1'b0;
    bus.cmd_wr_acc = 1'b1;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", bus.rsp_valid, 0);
    chk("mid_rst_ready", bus.cmd_ready, 1);
    chk("mid_rst_acc", bus.acc, 0);
    chk("mid_rst_count", bus.op_count, 0);
    chk("mid_rst_alu_a", bus.alu_a, 0);
    chk("mid_rst_data", bus.rsp_data, 0);
    @(negedge clk);
    chk("mid_rst_no_pulse", bus.rsp_valid, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential master for the team's 8-bit combinational ALU (the `alu` module: ops ADD/SUB/AND/OR/XOR/NOT A). It accepts operation commands over a valid/ready handshake, drives registered operands and the select onto the ALU, and captures result and carry_out. It returns a response with status flags over a second valid/ready handshake, and keeps an internal accumulator so chained operations run without the host re-supplying the previous result.

Parameters:
WIDTH, 8, operand/result/accumulator width; must match the ALU width.

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_sel  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT A; 110/111 illegal
cmd_a  input  WIDTH  operand A (ignored when cmd_use_acc=1)
cmd_b  input  WIDTH  operand B
cmd_use_acc  input  1  1 = take operand A from the accumulator
cmd_wr_acc  input  1  1 = write the result into the accumulator
alu_a  output  WIDTH  registered operand A to the ALU
alu_b  output  WIDTH  registered operand B to the ALU
alu_sel  output  3  registered select to the ALU
alu_result  input  WIDTH  ALU result
alu_carry  input  1  ALU carry_out
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts the response
rsp_data  output  WIDTH  captured result (0 on error)
rsp_carry  output  1  captured carry (0 on error)
rsp_zero  output  1  1 when rsp_data==0 and rsp_err==0
rsp_err  output  1  illegal opcode
acc  output  WIDTH  accumulator value
op_count  output  16  number of legal ops completed, wraps 0xFFFF->0x0000

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE.
  - alu_a, alu_b, alu_sel, acc, rsp_data, rsp_carry, rsp_zero, rsp_err, op_count all = 0.
  - rsp_valid=0, cmd_ready=1 (state-decoded).
  - rst overrides any in-flight command. That command is dropped, no response is produced, and acc is not written.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: cmd_ready=1.
    - Accept on cmd_valid&&cmd_ready at edge T.
    - Legal opcode: load alu_a (cmd_use_acc ? acc : cmd_a), alu_b=cmd_b, alu_sel=cmd_sel; latch cmd_wr_acc; go to EXEC.
    - Illegal opcode: rsp_data=0, rsp_carry=0, rsp_zero=0, rsp_err=1; go directly to RESP. alu_* and acc are unchanged.
  - EXEC (exactly 1 cycle): cmd_ready=0. The ALU inputs are stable for this whole cycle.
    - At the end of EXEC (edge T+1): rsp_data=alu_result, rsp_carry=alu_carry, rsp_zero=(alu_result==0), rsp_err=0.
    - If the latched wr_acc=1: acc=alu_result.
    - op_count increments; go to RESP.
  - RESP: rsp_valid=1 and cmd_ready=0.
    - All rsp_* signals are held stable until rsp_valid&&rsp_ready.
    - On that handshake edge: go to IDLE, rsp_valid drops next cycle.
- Latency and throughput:
  - Legal op: rsp_valid is high in the cycle after edge T+1, i.e. 2 edges after acceptance.
  - Illegal op: 1 edge after acceptance.
  - Minimum legal-op period is 3 cycles. There is no overlap: cmd_ready is low throughout EXEC and RESP.
- Arithmetic rules:
  - The sequencer does not recompute results. It captures the ALU outputs verbatim, including carry semantics per op.
  - rsp_zero is the sequencer's own compare.
- alu_a/alu_b/alu_sel hold their last values outside EXEC; there is no return to 0 after an op.
- When cmd_use_acc=1, the acc value at the acceptance edge is used. A write by the same command affects only later commands.
- Backpressure: rsp_ready may be held low indefinitely, with no timeout. cmd_valid asserted during EXEC/RESP is ignored and is not queued.

Test Plan:
1. After reset, issue the six legal ops from IDLE, each with a 3-cycle gap, with A=0x0F/B=0x01/ADD, A=0x10/B=0x02/SUB, then A=0xAA/B=0xCC for AND/OR/XOR/NOT A -> rsp_data 0x10, 0x0E, 0x88, 0xEE, 0x66, 0x55. rsp_err=0, op_count=6, rsp_valid 2 edges after each accept.
2. ADD A=0xFF B=0x01 wr_acc=1 -> rsp_data=0x00, rsp_carry=1, rsp_zero=1, acc=0x00.
3. Accumulator chain:
   - ADD cmd_a=0x05, B=0x03, wr_acc=1 -> acc=0x08.
   - Then ADD use_acc=1, B=0x02, wr_acc=1 -> rsp_data=0x0A, acc=0x0A.
   - Then XOR use_acc=1, B=0xFF, wr_acc=0 -> rsp_data=0xF5, acc stays 0x0A.
4. Illegal opcode sel=110 -> rsp_valid after 1 edge, rsp_err=1, rsp_data=0, alu_sel unchanged, acc and op_count unchanged.
5. Backpressure: hold rsp_ready=0 for 10 cycles while pulsing cmd_valid with a new command -> rsp_* stable, cmd_ready=0, new command not accepted; raise rsp_ready -> IDLE, then the new command is accepted.
6. Reset mid-op: assert rst during EXEC of an ADD with wr_acc=1 -> next cycle all outputs are at reset values, no rsp_valid pulse, acc=0, op_count=0, cmd_ready=1.
